// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, queue-entry type and prefetch sizing.
// FETCH_PREFETCH_EN selects a 2-deep prefetch queue; otherwise a single entry.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam int unsigned PC_W         = 32;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pcplus4;
  } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order prefetch FIFO: head is always slot 0, entries shift down on pop.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  qentry_t          push_data,
  input  logic             pop,
  output qentry_t          head,
  output logic [CNT_W-1:0] count
);

  qentry_t          mem   [DEPTH];
  qentry_t          mem_n [DEPTH];
  logic [CNT_W-1:0] wr_idx;

  // A push lands behind whatever survives this cycle's pop
  always_comb begin
    mem_n  = mem;
    wr_idx = count - CNT_W'(pop);
    if (pop) begin
      for (int i = 1; i < int'(DEPTH); i++) mem_n[i-1] = mem[i];
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == wr_idx) mem_n[i] = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      mem   <= mem_n;
      count <= clear ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC_F, credit-limited imem requests, prefetch queue,
// F->D register and decode redirects. FETCH_PREFETCH_EN enables 2-deep prefetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              pcsrcD,
  input  logic              jumpD,
  input  logic [ADDR_W-1:0] branch_targetD,
  input  logic [ADDR_W-1:0] jump_targetD,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instrD,
  output logic [ADDR_W-1:0] pcplus4D,
  output logic              validD
);

  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] rsp_pc4;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  count;
  logic [SUM_W-1:0]  in_use;
  logic              redirect;
  logic              pop;
  logic              push;
  logic              rsp;
  logic              grant;
  qentry_t           head;
  qentry_t           push_data;

  assign redirect = validD & (jumpD | pcsrcD) & ~stallD;
  assign target   = jumpD ? jump_targetD : branch_targetD;
  assign pop      = ~stallD & (count != '0);

  // Credits: in-flight fetches plus buffered words must leave room for one more
  assign in_use    = SUM_W'(outstanding) + SUM_W'(count) - SUM_W'(pop);
  assign imem_req  = rst & ~stallF & ~redirect & (in_use < SUM_W'(DEPTH));
  assign imem_addr = pc_f;
  assign grant     = imem_req & imem_gnt;

  // Responses with nothing outstanding are protocol errors and are ignored
  assign rsp     = imem_rvalid & (outstanding != '0);
  assign push    = rsp & (drop == '0) & ~redirect;
  assign rsp_pc4 = rsp_pc + ADDR_W'(4);

  assign push_data.instr   = imem_rdata;
  assign push_data.pcplus4 = PC_W'(rsp_pc4);

  fetch_queue u_queue (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (redirect),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // rsp_pc tracks the address of the next response that will be kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
      if (redirect) begin
        pc_f   <= target;
        rsp_pc <= target;
        // every fetch still in flight after this cycle is stale
        drop   <= outstanding - CNT_W'(rsp);
      end else begin
        if (grant) pc_f <= pc_f + ADDR_W'(4);
        if (push) rsp_pc <= rsp_pc4;
        if (rsp && (drop != '0)) drop <= drop - CNT_W'(1);
      end
    end
  end

  // F->D pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (redirect) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (count != '0) begin
        instrD   <= head.instr;
        pcplus4D <= ADDR_W'(head.pcplus4);
        validD   <= 1'b1;
      end else begin
        instrD <= NOP_INSTR;
        validD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable latency,
// program-order reference for D-stage contents and fetch addresses.
module tb_fetch_unit;
  import fetch_unit_pkg::DEPTH;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int HOLD = 3;

  logic        clk;
  logic        rst;
  logic        stallF, stallD, pcsrcD, jumpD;
  logic [31:0] branch_targetD, jump_targetD;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pcplus4D;
  logic        validD;

  fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .pcsrcD(pcsrcD), .jumpD(jumpD),
    .branch_targetD(branch_targetD), .jump_targetD(jump_targetD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors, miscompares, cyc, delivered;
  int gnt_mode, lat_min, lat_max, stallF_pct, stallD_pct, redir_pct, noise_pct, spur_pct;
  int hold_left, force_redir;
  logic [31:0] force_jt, force_bt;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  int          last_rdy;
  logic [31:0] exp_fetch, exp_d;
  logic        s_grant, s_valid, s_take, s_req, s_hold;
  logic [31:0] s_pc4, s_addr;
  int          first_grant, d_start;
  int          dl[$];
  logic        flag;

  // Memory contents: a fixed function of the word address
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_reset();
    pend_addr.delete();
    pend_rdy.delete();
    last_rdy = 0;
  endtask

  task automatic model_reset();
    exp_fetch = RST_PC;
    exp_d     = RST_PC;
  endtask

  // One clock cycle: drive at negedge, sample #1 later, update the reference
  task automatic step();
    logic        eligible;
    int          kind, rdy;
    logic [31:0] jt, bt;
    @(negedge clk);
    stallF = 1'($urandom_range(99) < stallF_pct);
    stallD = 1'($urandom_range(99) < stallD_pct);
    s_hold = 1'b0;
    if (hold_left > 0 && (hold_left < HOLD || validD)) begin
      stallD = 1'b1;
      hold_left--;
      s_hold = 1'b1;
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      2:       imem_gnt = 1'b0;
      default: imem_gnt = 1'($urandom_range(1));
    endcase
    if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end else if (pend_addr.size() == 0 && $urandom_range(99) < spur_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    eligible = validD && !stallD;
    jt = $urandom & 32'hFFFF_FFFC;
    bt = $urandom & 32'hFFFF_FFFC;
    s_take = 1'b0;
    jumpD  = 1'b0;
    pcsrcD = 1'b0;
    if (eligible && (force_redir >= 0 || $urandom_range(99) < redir_pct)) begin
      kind = (force_redir >= 0) ? force_redir : int'($urandom_range(2));
      if (force_redir >= 0) begin
        jt = force_jt;
        bt = force_bt;
      end
      jumpD       = (kind != 1);
      pcsrcD      = (kind != 0);
      s_take      = 1'b1;
      force_redir = -1;
    end else if (!eligible && $urandom_range(99) < noise_pct) begin
      jumpD  = 1'($urandom_range(1));
      pcsrcD = 1'($urandom_range(1));
    end
    jump_targetD   = jt;
    branch_targetD = bt;
    #1;
    s_req   = imem_req;
    s_valid = validD;
    s_pc4   = pcplus4D;
    if (validD) begin
      check("d_pcplus4", pcplus4D, exp_d + 32'd4);
      check("d_instr", instrD, word(exp_d));
      if (!stallD) delivered++;
    end
    if (s_take) check("req_in_redirect", 32'(imem_req), 32'd0);
    s_grant = imem_req && imem_gnt;
    if (s_grant) begin
      s_addr = imem_addr;
      check("fetch_addr", imem_addr, exp_fetch);
      pend_addr.push_back(imem_addr);
      rdy = cyc + int'($urandom_range(lat_max, lat_min));
      if (rdy <= last_rdy) rdy = last_rdy + 1;
      last_rdy = rdy;
      pend_rdy.push_back(rdy);
      check("credit_bound", 32'(pend_addr.size() <= int'(DEPTH)), 32'd1);
    end
    if (s_take) begin
      exp_fetch = jumpD ? jt : bt;
      exp_d     = exp_fetch;
    end else begin
      if (s_grant) exp_fetch = exp_fetch + 32'd4;
      if (validD && !stallD) exp_d = exp_d + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; delivered = 0;
    gnt_mode = 0; lat_min = 1; lat_max = 1;
    stallF_pct = 0; stallD_pct = 0; redir_pct = 0; noise_pct = 0; spur_pct = 0;
    hold_left = 0; force_redir = -1; force_jt = '0; force_bt = '0;
    rst = 1'b0; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    branch_targetD = '0; jump_targetD = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_reset();
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_validD", 32'(validD), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instrD", instrD, 32'd0);
    check("rst_pcplus4D", pcplus4D, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);

    // Always-granting 1-cycle memory: latency and delivery spacing
    first_grant = -1;
    dl.delete();
    for (int i = 0; i < 40 && dl.size() < 3; i++) begin
      step();
      if (s_grant && first_grant < 0) first_grant = cyc - 1;
      if (s_valid) dl.push_back(cyc - 1);
    end
    check("deliveries_seen", 32'(dl.size()), 32'd3);
    if (dl.size() == 3) begin
      check("first_valid_latency", 32'(dl[0] - first_grant), 32'd3);
      check("delivery_gap0", 32'(dl[1] - dl[0]), 32'(3 - int'(DEPTH)));
      check("delivery_gap1", 32'(dl[2] - dl[1]), 32'(3 - int'(DEPTH)));
    end

    // stallD held 3 cycles on a valid instruction
    hold_left = HOLD;
    for (int i = 0; i < 30 && hold_left > 0; i++) begin
      step();
      if (s_hold) begin
        check("stall_validD", 32'(s_valid), 32'd1);
        if (hold_left == 0) check("stall_req_off", 32'(s_req), 32'd0);
      end
    end
    check("stall_done", 32'(hold_left), 32'd0);
    repeat (10) step();

    // Jump with fetches in flight (3-cycle memory)
    lat_min = 3; lat_max = 3;
    repeat (10) step();
    force_jt = 32'h8000_0100; force_bt = 32'h1234_5670; force_redir = 0;
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin step(); flag = s_take; end
    force_redir = -1;
    check("jump_taken", 32'(flag), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin
      step();
      if (s_valid) begin flag = 1'b1; check("jump_first_pc4", s_pc4, 32'h8000_0104); end
    end
    check("jump_delivered", 32'(flag), 32'd1);

    // pcsrcD and jumpD together: jump target wins
    force_jt = 32'h0040_0000; force_bt = 32'h0000_1000; force_redir = 2;
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin step(); flag = s_take; end
    force_redir = -1;
    check("both_taken", 32'(flag), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin
      step();
      if (s_grant) begin flag = 1'b1; check("both_fetch_addr", s_addr, 32'h0040_0000); end
    end
    check("both_granted", 32'(flag), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin
      step();
      if (s_valid) begin flag = 1'b1; check("both_first_pc4", s_pc4, 32'h0040_0004); end
    end
    check("both_delivered", 32'(flag), 32'd1);

    // Grant withheld, pipeline drains to bubbles, then 3-cycle memory
    gnt_mode = 2;
    repeat (6) step();
    check("idle_validD", 32'(s_valid), 32'd0);
    gnt_mode = 0;
    d_start = delivered;
    repeat (30) step();
    check("resume_progress", 32'(delivered > d_start), 32'd1);

    // Asynchronous reset mid-stream
    @(negedge clk);
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; jumpD = 1'b0; pcsrcD = 1'b0;
    stallF = 1'b0; stallD = 1'b0;
    #1;
    check("midrst_validD", 32'(validD), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_instrD", instrD, 32'd0);
    mem_reset();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_addr", imem_addr, RST_PC);
    check("midrst_req_after", 32'(imem_req), 32'd1);

    // Randomised traffic
    gnt_mode = 1; lat_min = 1; lat_max = 4;
    stallF_pct = 20; stallD_pct = 20; redir_pct = 8; noise_pct = 15; spur_pct = 5;
    d_start = delivered;
    repeat (2000) step();
    check("random_progress", 32'(delivered - d_start > 50), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
